mmio_interconnect: RTL and testbench
====================================

Name: mmio_interconnect

Overview:
Parametrised MMIO bus interconnect between the multicycle CPU memory port and N memory-mapped slaves (BRAM, GPIO, future SPI flash/UART). It replaces fixed two-way combinational decode and the free-running delayed-address read mux with a per-transaction state machine. Slaves signal completion with a ready handshake, so they may have variable latency. Unmapped accesses and slaves that stall past a timeout are terminated with a bus error, and the failing address is recorded for debug.

Parameters:
N_SLAVES, 2, number of slave channels (1..8)
BASE_ADDRS, {32'hFFFF_FFF0, 32'h0000_0000}, packed N_SLAVES*32; slice k is the inclusive base of slave k
TOP_ADDRS, {32'hFFFF_FFF3, 32'h0000_07FF}, packed N_SLAVES*32; slice k is the inclusive top of slave k
TIMEOUT, 15, maximum WAIT cycles before a bus error; 0 disables the timeout
DEFAULT_RDATA, 32'h0000_0000, read data returned on error

Ports:
slowed_clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
host_req  input  1  transfer request; sampled only in IDLE
host_addr  input  32  byte address
host_wdata  input  32  write data
host_byte_mask  input  4  byte enables
host_write  input  1  1 = write, 0 = read
host_rdata  output  32  read data; valid while host_ready=1
host_ready  output  1  one-cycle completion pulse
host_err  output  1  error flag; valid with host_ready
s_sel  output  N_SLAVES  one-hot slave select
s_addr  output  32  latched address, broadcast to all slaves
s_wdata  output  32  latched write data
s_byte_mask  output  4  latched byte mask
s_write  output  1  latched write; gated by any s_sel bit
s_rdata  input  N_SLAVES*32  per-slave read data; slice k belongs to slave k
s_ready  input  N_SLAVES  per-slave completion signal
err_addr  output  32  address of the most recent errored transfer
err_count  output  8  saturating count of errored transfers

Behaviour:
- Reset (async): state=IDLE. All outputs are 0: s_sel, s_write, host_ready, host_err, host_rdata, s_addr, s_wdata, s_byte_mask, err_addr, err_count. The timeout counter is cleared.
- Reset mid-transfer: the transfer is abandoned, no host_ready pulse is issued, and s_sel drops immediately.
- Decode: slave k hits when BASE_k <= host_addr <= TOP_k, using unsigned compare. If ranges overlap, the lowest index wins.
- State IDLE:
  - On host_req=1, latch addr, wdata, byte_mask and write into the s_* registers.
  - On a hit, latch index k, set s_sel[k]=1 and go to WAIT.
  - On a miss, set host_err=1 and host_rdata=DEFAULT_RDATA, then go to RESP. No s_sel bit is asserted.
- State WAIT:
  - s_sel[k] and the s_* registers are held stable. The timeout counter increments each cycle.
  - If s_ready[k]=1: capture s_rdata slice k into host_rdata (also on writes), set host_err=0, clear s_sel and go to RESP.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: set host_err=1, host_rdata=DEFAULT_RDATA, clear s_sel and go to RESP.
  - If ready and timeout coincide, ready wins.
  - s_ready bits of unselected slaves are ignored.
- State RESP: host_ready=1 for exactly one cycle, then go to IDLE. host_rdata and host_err hold until the next transfer completes.
- Latency:
  - Hit with s_ready asserted in the first WAIT cycle: req accepted at edge 0, host_ready high after edge 2.
  - Miss: host_ready high after edge 1.
- host_req is ignored outside IDLE. The host may drop req after acceptance.
- Error logging: on entry to RESP with host_err=1, err_addr<=latched addr and err_count<=err_count+1, saturating at 255.
- s_write=latched write AND (|s_sel), so no slave sees a write while deselected.

Test Plan:
- Read BRAM at 0x0000_0004, slave 0 ready in the first WAIT cycle with s_rdata0=0xDEADBEEF -> s_sel=01 for 1 cycle; host_ready pulse 2 cycles after acceptance with rdata=0xDEADBEEF, err=0.
- Write GPIO at 0xFFFF_FFF0 with wdata=0x5, mask=0x1, slave 1 ready after 3 WAIT cycles -> s_sel=10 and s_write=1 stable for 3 cycles; host_ready with err=0; s_write drops with s_sel.
- Read unmapped 0x0000_1000 -> no s_sel; host_ready after 1 cycle with err=1, rdata=0; err_addr=0x0000_1000, err_count=1.
- Slave 0 never ready, TIMEOUT=15 -> s_sel held exactly 15 cycles, then host_ready with err=1; err_count increments.
- Slave ready on the same cycle as the timeout -> err=0 and slave data is returned.
- Assert reset in WAIT -> s_sel=0 immediately, no host_ready pulse; the next request then completes normally. Also drive 256 errors -> err_count stays 255.

Source files
------------

// File: rtl/mmio_interconnect.sv
// MMIO interconnect: address-decodes one CPU memory port onto N ready-handshake slaves,
// with bus errors for unmapped or stalled accesses and a debug log of the failing address.
module mmio_interconnect #(
  parameter int                     N_SLAVES      = 2,
  parameter logic [N_SLAVES*32-1:0] BASE_ADDRS    = {32'hFFFF_FFF0, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0] TOP_ADDRS     = {32'hFFFF_FFF3, 32'h0000_07FF},
  parameter int                     TIMEOUT       = 15,
  parameter logic [31:0]            DEFAULT_RDATA = 32'h0000_0000
) (
  input  logic                     slowed_clk,
  input  logic                     reset,
  input  logic                     host_req,
  input  logic [31:0]              host_addr,
  input  logic [31:0]              host_wdata,
  input  logic [3:0]               host_byte_mask,
  input  logic                     host_write,
  output logic [31:0]              host_rdata,
  output logic                     host_ready,
  output logic                     host_err,
  output logic [N_SLAVES-1:0]      s_sel,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_byte_mask,
  output logic                     s_write,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_ready,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count
);

  localparam int          IDX_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [N_SLAVES-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            mask_q, mask_d;
  logic                  write_q, write_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [7:0]            err_count_q, err_count_d;

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  log_err;

  // Scan from the top index down so the lowest matching slave wins on overlap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if (host_addr >= BASE_ADDRS[k*32 +: 32] && host_addr <= TOP_ADDRS[k*32 +: 32]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  assign sel_ready = s_ready[idx_q];
  assign sel_rdata = s_rdata[idx_q*32 +: 32];

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    log_err     = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (host_req) begin
          addr_d  = host_addr;
          wdata_d = host_wdata;
          mask_d  = host_byte_mask;
          write_d = host_write;
          if (hit) begin
            idx_d          = hit_idx;
            sel_d          = '0;
            sel_d[hit_idx] = 1'b1;
            state_d        = ST_WAIT;
          end else begin
            err_d   = 1'b1;
            rdata_d = DEFAULT_RDATA;
            log_err = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (sel_ready) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          sel_d   = '0;
          state_d = ST_RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          rdata_d = DEFAULT_RDATA;
          err_d   = 1'b1;
          sel_d   = '0;
          log_err = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (log_err) begin
      err_addr_d = addr_d;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge slowed_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      write_q     <= write_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign host_rdata  = rdata_q;
  assign host_ready  = ready_q;
  assign host_err    = err_q;
  assign s_sel       = sel_q;
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign s_byte_mask = mask_q;
  assign s_write     = write_q & (|sel_q);
  assign err_addr    = err_addr_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed bench for mmio_interconnect: two slaves (BRAM at 0x0, GPIO at 0xFFFF_FFF0), TIMEOUT=15.
module tb_mmio_interconnect;

  logic        slowed_clk = 1'b0;
  logic        reset;
  logic        host_req;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [3:0]  host_byte_mask;
  logic        host_write;
  logic [31:0] host_rdata;
  logic        host_ready;
  logic        host_err;
  logic [1:0]  s_sel;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_byte_mask;
  logic        s_write;
  logic [63:0] s_rdata;
  logic [1:0]  s_ready;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  always #5 slowed_clk = ~slowed_clk;

  mmio_interconnect dut (
    .slowed_clk     (slowed_clk),
    .reset          (reset),
    .host_req       (host_req),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_byte_mask (host_byte_mask),
    .host_write     (host_write),
    .host_rdata     (host_rdata),
    .host_ready     (host_ready),
    .host_err       (host_err),
    .s_sel          (s_sel),
    .s_addr         (s_addr),
    .s_wdata        (s_wdata),
    .s_byte_mask    (s_byte_mask),
    .s_write        (s_write),
    .s_rdata        (s_rdata),
    .s_ready        (s_ready),
    .err_addr       (err_addr),
    .err_count      (err_count)
  );

  task automatic test_reset();
    reset = 1'b1;
    host_req = 1'b0; host_addr = '0; host_wdata = '0; host_byte_mask = '0; host_write = 1'b0;
    s_rdata = '0; s_ready = '0;
    repeat (2) @(negedge slowed_clk);
    checks++;
    if ({s_sel, s_write, host_ready, host_err, host_rdata, s_addr, s_wdata, s_byte_mask,
         err_addr, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%b wr=%b rdy=%b err=%b rdata=%h addr=%h ecnt=%0d, expected all zero",
               s_sel, s_write, host_ready, host_err, host_rdata, s_addr, err_count);
    end
    reset = 1'b0;
    @(negedge slowed_clk);
  endtask

  task automatic test_read_hit();
    host_req = 1'b1; host_addr = 32'h0000_0004; host_write = 1'b0;
    host_wdata = 32'h0; host_byte_mask = 4'hF;
    s_rdata[31:0] = 32'hDEAD_BEEF;
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    host_req = 1'b0;
    checks++;
    if (s_sel !== 2'b01 || s_addr !== 32'h4 || host_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_sel: got sel=%b addr=%h rdy=%b, expected sel=01 addr=00000004 rdy=0", s_sel, s_addr, host_ready);
    end
    s_ready = 2'b01;
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    s_ready = 2'b00;
    checks++;
    if (s_sel !== 2'b00 || host_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_resp_state: got sel=%b rdy=%b, expected sel=00 rdy=0", s_sel, host_ready);
    end
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    checks++;
    if (host_ready !== 1'b1 || host_err !== 1'b0 || host_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_done: got rdy=%b err=%b rdata=%h, expected rdy=1 err=0 rdata=deadbeef", host_ready, host_err, host_rdata);
    end
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    checks++;
    if (host_ready !== 1'b0 || host_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_pulse_end: got rdy=%b rdata=%h, expected rdy=0 rdata=deadbeef", host_ready, host_rdata);
    end
  endtask

  task automatic test_write_gpio();
    host_req = 1'b1; host_addr = 32'hFFFF_FFF0; host_write = 1'b1;
    host_wdata = 32'h5; host_byte_mask = 4'h1;
    s_rdata[63:32] = 32'h0000_00A5;
    @(posedge slowed_clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge slowed_clk);
      host_req = 1'b0; host_write = 1'b0; host_wdata = '0; host_byte_mask = '0;
      checks++;
      if (s_sel !== 2'b10 || s_write !== 1'b1 || s_wdata !== 32'h5 || s_byte_mask !== 4'h1 || host_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_hold[%0d]: got sel=%b wr=%b wdata=%h mask=%h rdy=%b, expected sel=10 wr=1 wdata=5 mask=1 rdy=0",
                 i, s_sel, s_write, s_wdata, s_byte_mask, host_ready);
      end
      if (i == 2) s_ready = 2'b10;
      @(posedge slowed_clk);
    end
    @(negedge slowed_clk);
    s_ready = 2'b00;
    checks++;
    if (s_sel !== 2'b00 || s_write !== 1'b0) begin
      errors++;
      $display("FAIL write_release: got sel=%b wr=%b, expected sel=00 wr=0", s_sel, s_write);
    end
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    checks++;
    if (host_ready !== 1'b1 || host_err !== 1'b0 || host_rdata !== 32'hA5) begin
      errors++;
      $display("FAIL write_done: got rdy=%b err=%b rdata=%h, expected rdy=1 err=0 rdata=000000a5", host_ready, host_err, host_rdata);
    end
  endtask

  task automatic test_unmapped();
    host_req = 1'b1; host_addr = 32'h0000_1000; host_write = 1'b0;
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    host_req = 1'b0;
    checks++;
    if (s_sel !== 2'b00 || host_ready !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_nosel: got sel=%b rdy=%b, expected sel=00 rdy=0", s_sel, host_ready);
    end
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    checks++;
    if (host_ready !== 1'b1 || host_err !== 1'b1 || host_rdata !== 32'h0 ||
        err_addr !== 32'h0000_1000 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL unmapped_done: got rdy=%b err=%b rdata=%h eaddr=%h ecnt=%0d, expected 1 1 00000000 00001000 1",
               host_ready, host_err, host_rdata, err_addr, err_count);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit done = 0;
    host_req = 1'b1; host_addr = 32'h0000_0010; host_write = 1'b0;
    s_ready = 2'b10;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge slowed_clk);
      @(negedge slowed_clk);
      host_req = 1'b0;
      if (s_sel === 2'b01) n++;
      else done = 1;
    end
    s_ready = 2'b00;
    checks++;
    if (!done || n != 15) begin
      errors++;
      $display("FAIL timeout_sel_cycles: got %0d cycles (released=%0d), expected 15", n, done);
    end
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    checks++;
    if (host_ready !== 1'b1 || host_err !== 1'b1 || host_rdata !== 32'h0 ||
        err_count !== 8'd2 || err_addr !== 32'h10) begin
      errors++;
      $display("FAIL timeout_done: got rdy=%b err=%b rdata=%h ecnt=%0d eaddr=%h, expected 1 1 00000000 2 00000010",
               host_ready, host_err, host_rdata, err_count, err_addr);
    end
  endtask

  task automatic test_ready_at_timeout();
    host_req = 1'b1; host_addr = 32'h0000_0020; host_write = 1'b0;
    s_rdata[31:0] = 32'h1234_5678;
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    host_req = 1'b0;
    repeat (14) @(posedge slowed_clk);
    @(negedge slowed_clk);
    checks++;
    if (s_sel !== 2'b01) begin
      errors++;
      $display("FAIL coincide_still_wait: got sel=%b, expected 01", s_sel);
    end
    s_ready = 2'b01;
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    s_ready = 2'b00;
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    checks++;
    if (host_ready !== 1'b1 || host_err !== 1'b0 || host_rdata !== 32'h1234_5678 || err_count !== 8'd2) begin
      errors++;
      $display("FAIL coincide_done: got rdy=%b err=%b rdata=%h ecnt=%0d, expected 1 0 12345678 2",
               host_ready, host_err, host_rdata, err_count);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit seen = 0;
    bit pulse = 0;
    host_req = 1'b1; host_addr = 32'h0000_0004; host_write = 1'b1; host_wdata = 32'h77;
    @(posedge slowed_clk);
    @(negedge slowed_clk);
    host_req = 1'b0; host_write = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (s_sel !== 2'b00 || s_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_sel: got sel=%b wr=%b, expected sel=00 wr=0", s_sel, s_write);
    end
    @(negedge slowed_clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge slowed_clk);
      if (host_ready === 1'b1) pulse = 1;
    end
    checks++;
    if (pulse || err_count !== 8'd0 || err_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got pulse=%0d ecnt=%0d eaddr=%h, expected 0 0 00000000", pulse, err_count, err_addr);
    end
    s_rdata[31:0] = 32'hCAFE_0001;
    s_ready = 2'b01;
    host_req = 1'b1; host_addr = 32'h0000_0008;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(posedge slowed_clk);
      @(negedge slowed_clk);
      host_req = 1'b0;
      n++;
      if (host_ready === 1'b1) seen = 1;
    end
    s_ready = 2'b00;
    checks++;
    if (!seen || n != 3 || host_err !== 1'b0 || host_rdata !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL reset_mid_recover: got seen=%0d latency=%0d err=%b rdata=%h, expected 1 3 0 cafe0001",
               seen, n, host_err, host_rdata);
    end
  endtask

  task automatic test_err_saturate();
    host_addr = 32'h0000_2000; host_write = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge slowed_clk);
      host_req = 1'b1;
      @(posedge slowed_clk);
      @(negedge slowed_clk);
      host_req = 1'b0;
      @(posedge slowed_clk);
      if (i == 254) begin
        #1;
        checks++;
        if (err_count !== 8'd255) begin
          errors++;
          $display("FAIL err_count_255: got %0d, expected 255", err_count);
        end
      end
    end
    @(negedge slowed_clk);
    checks++;
    if (err_count !== 8'd255 || err_addr !== 32'h0000_2000) begin
      errors++;
      $display("FAIL err_count_sat: got ecnt=%0d eaddr=%h, expected 255 00002000", err_count, err_addr);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_gpio();
    test_unmapped();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid();
    test_err_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
